// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load extension, write-back mux, retire counter.
// Define WB_BYPASS_EN to forward the W-stage write into the D-stage read data.
module wb_stage #(
  parameter logic [31:0] RESET_PC8 = 32'h0000_3008
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        En,
  input  logic        Clr,
  input  logic        Valid_M,
  input  logic        RegWrite_M,
  input  logic [4:0]  A3_M,
  input  logic [1:0]  WBSel_M,
  input  logic [2:0]  LdType_M,
  input  logic [1:0]  ByteOff_M,
  input  logic [31:0] ALUOut_M,
  input  logic [31:0] DMRD_M,
  input  logic [31:0] PC8_M,
  output logic        RF_We,
  output logic [4:0]  RF_A3,
  output logic [31:0] RF_WD,
  output logic        Fwd_Valid_W,
  output logic [4:0]  Fwd_A3_W,
  output logic [31:0] Fwd_WD_W,
  input  logic [4:0]  A1_D,
  input  logic [4:0]  A2_D,
  input  logic [31:0] RF_RD1,
  input  logic [31:0] RF_RD2,
  output logic [31:0] RD1_D,
  output logic [31:0] RD2_D,
  output logic [31:0] Retire_Cnt
);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [4:0]  a3;
    logic [1:0]  wbsel;
    logic [2:0]  ldtype;
    logic [1:0]  byteoff;
    logic [31:0] aluout;
    logic [31:0] dmrd;
    logic [31:0] pc8;
  } w_reg_t;

  w_reg_t w, w_next;
  logic [31:0] cnt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    w_next = '{valid: Valid_M, regwrite: RegWrite_M, a3: A3_M, wbsel: WBSel_M,
               ldtype: LdType_M, byteoff: ByteOff_M, aluout: ALUOut_M,
               dmrd: DMRD_M, pc8: PC8_M};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      w     <= '0;
      w.pc8 <= RESET_PC8;
    end else if (Clr) begin
      w <= '0;
    end else if (En) begin
      w <= w_next;
    end
  end

  // An instruction retires when it leaves W, either advanced or flushed.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                 cnt <= '0;
    else if (w.valid && (En || Clr)) cnt <= cnt + 32'd1;
  end

  always_comb begin
    ld_byte = w.dmrd[8*w.byteoff +: 8];
    ld_half = w.byteoff[1] ? w.dmrd[31:16] : w.dmrd[15:0];
    case (w.ldtype)
      3'd1:    ld_data = {24'd0, ld_byte};
      3'd2:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd3:    ld_data = {16'd0, ld_half};
      3'd4:    ld_data = {{16{ld_half[15]}}, ld_half};
      default: ld_data = w.dmrd;
    endcase
  end

  always_comb begin
    case (w.wbsel)
      2'd1:    RF_WD = ld_data;
      2'd2:    RF_WD = w.pc8;
      default: RF_WD = w.aluout;
    endcase
  end

  assign RF_We       = w.valid & w.regwrite & (w.a3 != 5'd0);
  assign RF_A3       = w.a3;
  assign Fwd_Valid_W = RF_We;
  assign Fwd_A3_W    = RF_A3;
  assign Fwd_WD_W    = RF_WD;
  assign Retire_Cnt  = cnt;

`ifdef WB_BYPASS_EN
  assign RD1_D = (RF_We && (A1_D == RF_A3)) ? RF_WD : RF_RD1;
  assign RD2_D = (RF_We && (A2_D == RF_A3)) ? RF_WD : RF_RD2;
`else
  logic unused_d;
  assign unused_d = ^{A1_D, A2_D};
  assign RD1_D    = RF_RD1;
  assign RD2_D    = RF_RD2;
`endif

endmodule
